// File: rtl/allophone_queue.sv
// Allophone FIFO feeding a speech core through a ldq/data_stb handshake.
// Codes are queued on wr_stb and handed to the core one at a time: when the core raises ldq
// with data waiting, the head code is latched onto data_out and strobed for one cycle, then
// the block waits for ldq to drop before offering the next code.
// Optional feature: define ALLOPHONE_QUEUE_OVERFLOW_EN to build the sticky overflow flag.
module allophone_queue #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_an,
  input  logic [5:0]            wr_data,
  input  logic                  wr_stb,
  input  logic                  flush,
  input  logic                  ldq,
  output logic [5:0]            data_out,
  output logic                  data_stb,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FullCount = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]   CntOne    = 1;
  localparam logic [DEPTH_LOG2-1:0] PtrOne    = 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  logic [5:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [1:0]            state_q, state_d;
  logic [5:0]            data_q, data_d;
  logic                  wr_ok;
  logic                  pop;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign count = count_q;

  // A full FIFO drops the write even if a pop frees a slot in the same cycle.
  assign wr_ok = wr_stb && !full && !flush;
  assign pop   = (state_q == StIdle) && ldq && !empty && !flush;

  // Pointer, occupancy, FSM and output-latch next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    data_d   = data_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)   rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({wr_ok, pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end

    case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StLoad;
          data_d  = mem_q[rd_ptr_q];
        end
      end
      StLoad:  state_d = StWait;
      StWait:  if (!ldq) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_an) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      data_q   <= 6'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      data_q   <= data_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (rst_an && wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign data_out = data_q;
  assign data_stb = (state_q == StLoad);
  assign busy     = (state_q != StIdle) || !empty;

`ifdef ALLOPHONE_QUEUE_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Sticky record of writes lost to a full FIFO; only reset or flush clears it.
  always_comb begin
    ovf_d = ovf_q;
    if (flush)              ovf_d = 1'b0;
    else if (wr_stb && full) ovf_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (!rst_an) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_allophone_queue.sv
// Bench for allophone_queue: a fixed vector table for the basic load handshake, directed
// sequences for full/overflow, pop-while-full, reset mid-transfer, flush and pointer wrap,
// then random traffic compared every cycle against a queue-based reference model.
module tb_allophone_queue;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 2 ** DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                rst_an = 1'b0;
  logic [5:0]          wr_data = 6'h00;
  logic                wr_stb = 1'b0;
  logic                flush = 1'b0;
  logic                ldq = 1'b0;
  logic [5:0]          data_out;
  logic                data_stb;
  logic [DEPTH_LOG2:0] count;
  logic                full;
  logic                empty;
  logic                busy;
  logic                overflow;

  allophone_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk      (clk),
    .rst_an   (rst_an),
    .wr_data  (wr_data),
    .wr_stb   (wr_stb),
    .flush    (flush),
    .ldq      (ldq),
    .data_out (data_out),
    .data_stb (data_stb),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .overflow (overflow)
  );

  always #200 clk = ~clk;

`ifdef ALLOPHONE_QUEUE_OVERFLOW_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the FIFO as a queue plus the handshake described as
  // "strobe due this cycle" and "transfer open until the core drops ldq".
  logic [5:0] mq[$];
  bit         m_xfer = 1'b0;
  bit         m_stb  = 1'b0;
  logic [5:0] m_out  = 6'h00;
  bit         m_ovf  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
  endtask

  task automatic model_edge(input bit r, input bit w, input logic [5:0] d, input bit f,
                            input bit l);
    int sz;
    bit do_pop;
    sz = mq.size();
    do_pop = 1'b0;
    if (!r) begin
      mq.delete();
      m_xfer = 1'b0;
      m_stb  = 1'b0;
      m_out  = 6'h00;
      m_ovf  = 1'b0;
    end else begin
      if (m_stb) m_stb = 1'b0;
      else if (m_xfer) begin
        if (!l) m_xfer = 1'b0;
      end else if (l && sz != 0 && !f) begin
        do_pop = 1'b1;
        m_xfer = 1'b1;
        m_stb  = 1'b1;
      end
      if (f) begin
        mq.delete();
        m_ovf = 1'b0;
      end else begin
        if (do_pop) m_out = mq.pop_front();
        if (w && sz < DEPTH) mq.push_back(d);
        else if (w && OvfEn) m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("model.count", 32'(count), 32'(mq.size()));
    chk("model.empty", 32'(empty), 32'(mq.size() == 0));
    chk("model.full", 32'(full), 32'(mq.size() == DEPTH));
    chk("model.busy", 32'(busy), 32'(m_xfer || mq.size() != 0));
    chk("model.data_stb", 32'(data_stb), 32'(m_stb));
    chk("model.data_out", 32'(data_out), 32'(m_out));
    chk("model.overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Apply one cycle of inputs, advance the model over the same edge, then compare.
  task automatic step(input bit r, input bit w, input logic [5:0] d, input bit f, input bit l);
    rst_an  = r;
    wr_stb  = w;
    wr_data = d;
    flush   = f;
    ldq     = l;
    @(posedge clk);
    model_edge(r, w, d, f, l);
    #1;
    check_model();
  endtask

  typedef struct {
    bit         r, w, f, l;
    logic [5:0] d;
    int         cnt;
    bit         stb;
    logic [5:0] out;
    bit         emp, busy;
  } vec_t;

  vec_t vt[14];

  initial begin
    // rst, wr, flush, ldq, data | count, stb, out, empty, busy
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 0, 1'b0, 6'h00, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'h1B, 1, 1'b0, 6'h00, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'h07, 2, 1'b0, 6'h00, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'h2D, 3, 1'b0, 6'h00, 1'b0, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 3, 1'b0, 6'h00, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 2, 1'b1, 6'h1B, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 2, 1'b0, 6'h1B, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 2, 1'b0, 6'h1B, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 1, 1'b1, 6'h07, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1, 1'b0, 6'h07, 1'b0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1, 1'b0, 6'h07, 1'b0, 1'b1};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 0, 1'b1, 6'h2D, 1'b1, 1'b1};
    vt[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 0, 1'b0, 6'h2D, 1'b1, 1'b1};
    vt[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 0, 1'b0, 6'h2D, 1'b1, 1'b0};

    for (int i = 0; i < 14; i++) begin
      step(vt[i].r, vt[i].w, vt[i].d, vt[i].f, vt[i].l);
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d.data_stb", i), 32'(data_stb), 32'(vt[i].stb));
      chk($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(vt[i].out));
      chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(vt[i].emp));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vt[i].busy));
    end

    // Fill past capacity: the 17th write is dropped.
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b1, 6'(i + 8'h20), 1'b0, 1'b0);
    chk("fill.count", 32'(count), 32'(DEPTH));
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.overflow", 32'(overflow), 32'(OvfEn));

    // Write while full on the pop cycle is still dropped.
    step(1'b1, 1'b1, 6'h3F, 1'b0, 1'b1);
    chk("popfull.count", 32'(count), 32'(DEPTH - 1));
    chk("popfull.data_stb", 32'(data_stb), 32'd1);
    chk("popfull.data_out", 32'(data_out), 32'h20);

    // Reset while waiting with ldq held high aborts the transfer.
    step(1'b1, 1'b0, 6'h00, 1'b0, 1'b1);
    step(1'b1, 1'b0, 6'h00, 1'b0, 1'b1);
    chk("wait.data_stb", 32'(data_stb), 32'd0);
    step(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.data_stb", 32'(data_stb), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.data_out", 32'(data_out), 32'h00);
    step(1'b1, 1'b0, 6'h00, 1'b0, 1'b1);
    chk("postrst.data_stb", 32'(data_stb), 32'd0);

    // Flush with a simultaneous write leaves the FIFO empty.
    step(1'b1, 1'b1, 6'h11, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'h12, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'h13, 1'b1, 1'b0);
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.empty", 32'(empty), 32'd1);

    // 20 single-entry round trips carry the pointers across the wrap.
    for (int i = 0; i < 20; i++) begin
      logic [5:0] code;
      code = 6'((i * 5 + 3) & 63);
      step(1'b1, 1'b1, code, 1'b0, 1'b0);
      step(1'b1, 1'b0, 6'h00, 1'b0, 1'b1);
      chk($sformatf("wrap%0d.data_stb", i), 32'(data_stb), 32'd1);
      chk($sformatf("wrap%0d.data_out", i), 32'(data_out), 32'(code));
      step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
      step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    end
    chk("wrap.empty", 32'(empty), 32'd1);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0),
           6'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
